// File: rtl/sum_disp_pkg.sv
// Shared constants and types for the adder-sum 7-segment display.
// Segment codes are active-low {g,f,e,d,c,b,a}; digit enables are active-low.
package sum_disp_pkg;

    localparam int unsigned VAL_W   = 5;   // captured {carry, sum}
    localparam int unsigned SUM_W   = 4;
    localparam int unsigned DIGIT_W = 4;   // BCD ones digit
    localparam int unsigned TENS_W  = 2;   // tens digit is 0..3
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 2;

    localparam logic [SEG_W-1:0] SEG_0   = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h10;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    localparam logic [AN_W-1:0] AN_ONES = 2'b10;
    localparam logic [AN_W-1:0] AN_TENS = 2'b01;
    localparam logic [AN_W-1:0] AN_OFF  = 2'b11;

    typedef logic [VAL_W-1:0] disp_val_t;

endpackage

// File: rtl/sum_seg_display_if.sv
// Bus between the ripple adder side and the display block.
// master: drives sum_in/carry_in/load, observes seg/an/ovf/valid.
// slave : the display block.
interface sum_seg_display_if;
    import sum_disp_pkg::*;

    logic [SUM_W-1:0] sum_in;
    logic             carry_in;
    logic             load;
    logic [SEG_W-1:0] seg;
    logic [AN_W-1:0]  an;
    logic             ovf;
    logic             valid;

    modport master (
        output sum_in, carry_in, load,
        input  seg, an, ovf, valid
    );

    modport slave (
        input  sum_in, carry_in, load,
        output seg, an, ovf, valid
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment code.
// Ports: digit_i (4-bit digit), seg_c_o (7-bit {g..a} code, unregistered).
module seg7_decode
    import sum_disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [SEG_W-1:0]   seg_c_o
);

    always_comb begin
        seg_c_o = SEG_OFF;
        case (digit_i)
            4'd0:    seg_c_o = SEG_0;
            4'd1:    seg_c_o = SEG_1;
            4'd2:    seg_c_o = SEG_2;
            4'd3:    seg_c_o = SEG_3;
            4'd4:    seg_c_o = SEG_4;
            4'd5:    seg_c_o = SEG_5;
            4'd6:    seg_c_o = SEG_6;
            4'd7:    seg_c_o = SEG_7;
            4'd8:    seg_c_o = SEG_8;
            4'd9:    seg_c_o = SEG_9;
            default: seg_c_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sum_seg_display.sv
// Captures a 4-bit adder sum plus carry (0..31), converts it to two BCD digits
// and drives a 2-digit time-multiplexed common-anode 7-segment display.
// Ports: clk, rst (sync, active-high), bus (slave modport: sum_in, carry_in,
// load in; seg, an, ovf, valid out, all registered).
// Parameters: SCAN_DIV clock cycles per digit phase, SCAN_W divider width.
// Optional: define SUM_DISP_LEADING_ZERO_BLANK_EN to darken a zero tens digit.
module sum_seg_display
    import sum_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned SCAN_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    sum_seg_display_if.slave    bus
);

    disp_val_t           val_q,     val_d;
    logic [TENS_W-1:0]   tens_q,    tens_d;
    logic [DIGIT_W-1:0]  ones_q,    ones_d;
    logic [SCAN_W-1:0]   div_cnt_q, div_cnt_d;
    logic                phase_q,   phase_d;
    logic [SEG_W-1:0]    seg_q,     seg_d;
    logic [AN_W-1:0]     an_q,      an_d;
    logic                ovf_q,     ovf_d;
    logic                valid_q,   valid_d;

    logic [DIGIT_W-1:0]  digit_sel_c;
    logic [SEG_W-1:0]    seg_code_c;

    // Capture stage: last load wins.
    always_comb begin
        val_d   = val_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        if (bus.load) begin
            val_d   = {bus.carry_in, bus.sum_in};
            ovf_d   = bus.carry_in;
            valid_d = 1'b1;
        end
    end

    // Binary to BCD by range compare and constant subtract (value <= 31).
    always_comb begin
        tens_d = '0;
        ones_d = DIGIT_W'(val_q);
        if (val_q >= 5'd30) begin
            tens_d = 2'd3;
            ones_d = DIGIT_W'(val_q - 5'd30);
        end else if (val_q >= 5'd20) begin
            tens_d = 2'd2;
            ones_d = DIGIT_W'(val_q - 5'd20);
        end else if (val_q >= 5'd10) begin
            tens_d = 2'd1;
            ones_d = DIGIT_W'(val_q - 5'd10);
        end
    end

    // Free-running scan divider; phase flips on counter wrap.
    always_comb begin
        div_cnt_d = div_cnt_q + SCAN_W'(1);
        phase_d   = phase_q;
        if (div_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            div_cnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    // Single shared decoder; the mux picks the digit for the current phase.
    assign digit_sel_c = phase_q ? DIGIT_W'(tens_q) : ones_q;

    seg7_decode u_decode (
        .digit_i (digit_sel_c),
        .seg_c_o (seg_code_c)
    );

    // Output register: dark until something has been captured.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (valid_q) begin
            if (!phase_q) begin
                an_d  = AN_ONES;
                seg_d = seg_code_c;
            end else begin
`ifdef SUM_DISP_LEADING_ZERO_BLANK_EN
                if (tens_q != '0) begin
                    an_d  = AN_TENS;
                    seg_d = seg_code_c;
                end
`else
                an_d  = AN_TENS;
                seg_d = seg_code_c;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q     <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            val_q     <= val_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.ovf   = ovf_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_sum_seg_display.sv
// Scoreboard bench for sum_seg_display: driver pushes the expected outputs of
// every clock edge, a negedge monitor pops and compares.
module tb_sum_seg_display;

    localparam int unsigned SCAN_DIV = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       ovf;
        logic       valid;
    } exp_t;

    logic clk;
    logic rst;
    sum_seg_display_if bus ();

    sum_seg_display #(.SCAN_DIV(SCAN_DIV), .SCAN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: value latched, value currently shown, scan position.
    int   cap_val    = 0;
    int   shown_val  = 0;
    logic m_ovf      = 1'b0;
    logic m_valid    = 1'b0;
    logic valid_prev = 1'b0;
    int   ph_cnt     = 0;

    // Expected outputs right after one clock edge with the given inputs.
    task automatic model_edge(input logic r, input logic l,
                              input logic [3:0] s, input logic c);
        exp_t e;
        int   phase;
        if (r) begin
            cap_val = 0; shown_val = 0; m_ovf = 0; m_valid = 0;
            valid_prev = 0; ph_cnt = 0;
            e = '{seg: 7'h7F, an: 2'b11, ovf: 1'b0, valid: 1'b0};
        end else begin
            phase = (ph_cnt / int'(SCAN_DIV)) % 2;
            e.seg = 7'h7F;
            e.an  = 2'b11;
            if (valid_prev) begin
                if (phase == 0) begin
                    e.an  = 2'b10;
                    e.seg = seg_tab[shown_val % 10];
                end else begin
`ifdef SUM_DISP_LEADING_ZERO_BLANK_EN
                    if (shown_val / 10 != 0) begin
                        e.an  = 2'b01;
                        e.seg = seg_tab[shown_val / 10];
                    end
`else
                    e.an  = 2'b01;
                    e.seg = seg_tab[shown_val / 10];
`endif
                end
            end
            // Digits seen at the next edge come from the value held now.
            shown_val = cap_val;
            if (l) begin
                cap_val = int'({c, s});
                m_ovf   = c;
                m_valid = 1'b1;
            end
            e.ovf      = m_ovf;
            e.valid    = m_valid;
            valid_prev = m_valid;
            ph_cnt++;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic l,
                         input logic [3:0] s, input logic c);
        rst          = r;
        bus.load     = l;
        bus.sum_in   = s;
        bus.carry_in = c;
        @(posedge clk);
        model_edge(r, l, s, c);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'($urandom), 1'($urandom));
    endtask

    // Monitor: compare every presented output against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.seg !== e.seg || bus.an !== e.an ||
                    bus.ovf !== e.ovf || bus.valid !== e.valid) begin
                    errors++;
                    $display("FAIL outputs t=%0t got seg=%h an=%b ovf=%b valid=%b expected seg=%h an=%b ovf=%b valid=%b",
                             $time, bus.seg, bus.an, bus.ovf, bus.valid,
                             e.seg, e.an, e.ovf, e.valid);
                end
            end
        end
    end

    initial begin
        logic r, l, c;
        logic [3:0] s;

        // Reset, then idle with nothing captured.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'hF, 1'b1);
        idle(10);

        // Maximum value 31 and scan timing.
        cycle(1'b0, 1'b1, 4'hF, 1'b1);
        idle(20);

        // Leading zero on the tens digit.
        cycle(1'b0, 1'b1, 4'h7, 1'b0);
        idle(16);

        // Back-to-back loads, last one wins.
        cycle(1'b0, 1'b1, 4'h3, 1'b0);
        cycle(1'b0, 1'b1, 4'h9, 1'b0);
        cycle(1'b0, 1'b1, 4'hC, 1'b0);
        idle(16);

        // Reset while 31 is being scanned.
        cycle(1'b0, 1'b1, 4'hF, 1'b1);
        idle(5);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        idle(10);
        cycle(1'b0, 1'b1, 4'h5, 1'b1);
        idle(12);

        // Randomized traffic including loads coincident with reset.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 3) == 0);
            s = 4'($urandom);
            c = 1'($urandom);
            cycle(r, l, s, c);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
